// File: rtl/r2sdf_stage.sv
`default_nettype none
// ============================================================================
//  Module      : r2sdf_stage
//  Description : Parametrised radix-2 single-path delay-feedback FFT stage.
//                D-deep feedback delay line, butterfly, rounded/saturated
//                twiddle multiply against a shared external ROM, explicit
//                frame-end drain and priming-aware output valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module r2sdf_stage #(
    parameter int DW    = 35,
    parameter int LOG2D = 2,
    parameter int TWW   = 16,
    parameter int TW_EN = 1
) (
    input  logic             iClk,
    input  logic             Rst,
    input  logic             iData_valid,
    input  logic [DW-1:0]    iData_Re,
    input  logic [DW-1:0]    iData_Im,
    input  logic             iLast,
    output logic [LOG2D-1:0] oTw_Idx,
    input  logic [TWW-1:0]   iTw_Re,
    input  logic [TWW-1:0]   iTw_Im,
    output logic             oData_valid,
    output logic [DW:0]      oData_Re,
    output logic [DW:0]      oData_Im,
    output logic             oBusy
);

    localparam int c_DEPTH = 1 << LOG2D;
    // Product width: head (DW+1) times twiddle (TWW), plus one bit for the
    // sum of two products.
    localparam int c_PW    = DW + TWW + 2;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    localparam logic [LOG2D:0] c_CNT_ONE   = {{LOG2D{1'b0}}, 1'b1};
    localparam logic [LOG2D:0] c_CNT_LAST  = {(LOG2D+1){1'b1}};
    localparam logic [LOG2D:0] c_CNT_DRAIN = {1'b0, {LOG2D{1'b1}}};

    localparam logic signed [c_PW-1:0] c_SAT_MAX = {{(c_PW-DW){1'b0}}, {DW{1'b1}}};
    localparam logic signed [c_PW-1:0] c_SAT_MIN = {{(c_PW-DW){1'b1}}, {DW{1'b0}}};
    localparam logic signed [c_PW-1:0] c_RND     = {{(c_PW-TWW+1){1'b0}}, 1'b1, {(TWW-2){1'b0}}};

    logic [1:0]        r_state;
    logic [LOG2D:0]    r_cnt;
    logic              r_primed;
    logic signed [DW:0] r_dlRe [c_DEPTH];
    logic signed [DW:0] r_dlIm [c_DEPTH];

    logic               w_drain;
    logic               w_accept;
    logic               w_step;
    logic               w_phaseB;
    logic               w_drainEnd;
    logic               w_outValid;
    logic signed [DW:0] w_headRe;
    logic signed [DW:0] w_headIm;
    logic signed [DW:0] w_xRe;
    logic signed [DW:0] w_xIm;
    logic signed [DW:0] w_sumRe;
    logic signed [DW:0] w_sumIm;
    logic signed [DW:0] w_diffRe;
    logic signed [DW:0] w_diffIm;
    logic signed [DW:0] w_twRe;
    logic signed [DW:0] w_twIm;

    // Clamp a rounded product to the DW+1-bit signed output range.
    function automatic logic [DW:0] satFn(input logic signed [c_PW-1:0] v);
        if (v > c_SAT_MAX)
            return {1'b0, {DW{1'b1}}};
        else if (v < c_SAT_MIN)
            return {1'b1, {DW{1'b0}}};
        else
            return v[DW:0];
    endfunction

    assign w_drain    = (r_state == c_DRAIN);
    assign w_accept   = iData_valid && !w_drain;
    assign w_step     = w_accept || w_drain;
    assign w_phaseB   = r_cnt[LOG2D];
    assign w_drainEnd = w_drain && (r_cnt == c_CNT_DRAIN);
    assign oBusy      = w_drain;

    assign w_headRe = r_dlRe[c_DEPTH-1];
    assign w_headIm = r_dlIm[c_DEPTH-1];
    assign w_xRe    = {iData_Re[DW-1], iData_Re};
    assign w_xIm    = {iData_Im[DW-1], iData_Im};

    // DW+1 bits always hold the sum/difference of two DW-bit values.
    assign w_sumRe  = w_headRe + w_xRe;
    assign w_sumIm  = w_headIm + w_xIm;
    assign w_diffRe = w_headRe - w_xRe;
    assign w_diffIm = w_headIm - w_xIm;

    // Phase B always emits; phase A only once the line holds real
    // differences; every drain step emits.
    assign w_outValid = w_step && (w_phaseB || r_primed || w_drain);

    // The ROM is addressed only in phase A; held at zero when bypassed.
    assign oTw_Idx = ((TW_EN != 0) && !w_phaseB) ? r_cnt[LOG2D-1:0] : {LOG2D{1'b0}};

    generate
        if (TW_EN != 0) begin : g_twiddle
            logic signed [c_PW-1:0] w_a;
            logic signed [c_PW-1:0] w_b;
            logic signed [c_PW-1:0] w_c;
            logic signed [c_PW-1:0] w_d;
            logic signed [c_PW-1:0] w_pRe;
            logic signed [c_PW-1:0] w_pIm;
            logic signed [c_PW-1:0] w_shRe;
            logic signed [c_PW-1:0] w_shIm;

            assign w_a = {{(c_PW-DW-1){w_headRe[DW]}}, w_headRe};
            assign w_b = {{(c_PW-DW-1){w_headIm[DW]}}, w_headIm};
            assign w_c = {{(c_PW-TWW){iTw_Re[TWW-1]}}, iTw_Re};
            assign w_d = {{(c_PW-TWW){iTw_Im[TWW-1]}}, iTw_Im};

            // Round-half-up before dropping the Q1.(TWW-1) fraction bits.
            assign w_pRe  = (w_a * w_c) - (w_b * w_d) + c_RND;
            assign w_pIm  = (w_a * w_d) + (w_b * w_c) + c_RND;
            assign w_shRe = w_pRe >>> (TWW-1);
            assign w_shIm = w_pIm >>> (TWW-1);

            assign w_twRe = satFn(w_shRe);
            assign w_twIm = satFn(w_shIm);
        end else begin : g_bypass
            logic w_unusedTw;
            assign w_unusedTw = ^{iTw_Re, iTw_Im};
            assign w_twRe     = w_headRe;
            assign w_twIm     = w_headIm;
        end
    endgenerate

    // Control: phase counter, priming flag and IDLE/RUN/DRAIN sequencing.
    always_ff @(posedge iClk or posedge Rst) begin
        if (Rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_primed <= 1'b0;
        end else if (w_step) begin
            case (r_state)
                c_IDLE:  r_state <= c_RUN;
                c_RUN:   if (iLast && (r_cnt == c_CNT_LAST)) r_state <= c_DRAIN;
                c_DRAIN: if (w_drainEnd) r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase

            if (w_drainEnd)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + c_CNT_ONE;

            if (w_drainEnd)
                r_primed <= 1'b0;
            else if (!w_phaseB && (r_cnt[LOG2D-1:0] == {LOG2D{1'b1}}))
                r_primed <= 1'b1;
        end
    end

    // Feedback delay line: shifts once per step; phase A stores the input
    // (zero while draining), phase B stores the butterfly difference.
    always_ff @(posedge iClk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_dlRe[i] <= '0;
                r_dlIm[i] <= '0;
            end
        end else if (w_step) begin
            if (w_phaseB) begin
                r_dlRe[0] <= w_diffRe;
                r_dlIm[0] <= w_diffIm;
            end else if (w_drain) begin
                r_dlRe[0] <= '0;
                r_dlIm[0] <= '0;
            end else begin
                r_dlRe[0] <= w_xRe;
                r_dlIm[0] <= w_xIm;
            end
            for (int i = 1; i < c_DEPTH; i++) begin
                r_dlRe[i] <= r_dlRe[i-1];
                r_dlIm[i] <= r_dlIm[i-1];
            end
        end
    end

    // Registered output: sum in phase B, twiddled head otherwise.
    always_ff @(posedge iClk or posedge Rst) begin
        if (Rst) begin
            oData_valid <= 1'b0;
            oData_Re    <= '0;
            oData_Im    <= '0;
        end else begin
            oData_valid <= w_outValid;
            if (w_outValid) begin
                if (w_phaseB) begin
                    oData_Re <= w_sumRe;
                    oData_Im <= w_sumIm;
                end else begin
                    oData_Re <= w_twRe;
                    oData_Im <= w_twIm;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_r2sdf_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_r2sdf_stage
//  Description : Self-checking bench for r2sdf_stage (DW=8, LOG2D=2, TWW=8),
//                bypass and twiddle instances driven with shared stimulus and
//                compared against a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_r2sdf_stage;

    localparam int DW    = 8;
    localparam int LOG2D = 2;
    localparam int TWW   = 8;
    localparam int D     = 4;

    logic                 iClk = 1'b0;
    logic                 Rst  = 1'b1;
    logic                 dValid = 1'b0;
    logic                 dLast  = 1'b0;
    logic [DW-1:0]        dRe = '0;
    logic [DW-1:0]        dIm = '0;
    logic signed [TWW-1:0] romRe [D];
    logic signed [TWW-1:0] romIm [D];
    logic [TWW-1:0]       twRe;
    logic [TWW-1:0]       twIm;
    logic [LOG2D-1:0]     idxByp, idxTw;
    logic                 vByp, vTw, busyByp, busyTw;
    logic [DW:0]          bRe, bIm, tRe, tIm;

    int nAssert = 0;
    int nFail   = 0;
    int busySeen;

    longint capB[$];
    longint capTRe[$];
    longint capTIm[$];

    // Reference model state: frame position, first-half samples, differences.
    int     mPos;
    bit     mPrimed, mDrain;
    longint hRe[D], hIm[D], fRe[D], fIm[D];

    always #5 iClk = ~iClk;

    // Shared twiddle ROM, addressed by the twiddle instance.
    always_comb begin
        twRe = romRe[idxTw];
        twIm = romIm[idxTw];
    end

    r2sdf_stage #(.DW(DW), .LOG2D(LOG2D), .TWW(TWW), .TW_EN(0)) uByp (
        .iClk(iClk), .Rst(Rst), .iData_valid(dValid), .iData_Re(dRe), .iData_Im(dIm),
        .iLast(dLast), .oTw_Idx(idxByp), .iTw_Re(twRe), .iTw_Im(twIm),
        .oData_valid(vByp), .oData_Re(bRe), .oData_Im(bIm), .oBusy(busyByp));

    r2sdf_stage #(.DW(DW), .LOG2D(LOG2D), .TWW(TWW), .TW_EN(1)) uTw (
        .iClk(iClk), .Rst(Rst), .iData_valid(dValid), .iData_Re(dRe), .iData_Im(dIm),
        .iLast(dLast), .oTw_Idx(idxTw), .iTw_Re(twRe), .iTw_Im(twIm),
        .oData_valid(vTw), .oData_Re(tRe), .oData_Im(tIm), .oBusy(busyTw));

    task automatic checkVal(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
        nAssert++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint satv(input longint v);
        longint hi = (longint'(1) << DW) - 1;
        longint lo = -(longint'(1) << DW);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Complex multiply by a Q1.(TWW-1) twiddle with round-half-up and clamp.
    task automatic cmul(input longint a, input longint b, input longint c, input longint d,
                        output longint re, output longint im);
        longint half = longint'(1) << (TWW-2);
        re = satv((a*c - b*d + half) >>> (TWW-1));
        im = satv((a*d + b*c + half) >>> (TWW-1));
    endtask

    task automatic modelReset();
        mPos = 0; mPrimed = 0; mDrain = 0;
        for (int k = 0; k < D; k++) begin
            hRe[k] = 0; hIm[k] = 0; fRe[k] = 0; fIm[k] = 0;
        end
    endtask

    task automatic modelStep(input bit v, input longint xr, input longint xi, input bit lst,
                             output bit ev, output longint eBr, output longint eBi,
                             output longint eTr, output longint eTi);
        int k;
        ev = 0; eBr = 0; eBi = 0; eTr = 0; eTi = 0;
        if (mDrain) begin
            ev = 1;
            eBr = fRe[mPos]; eBi = fIm[mPos];
            cmul(fRe[mPos], fIm[mPos], longint'(romRe[mPos]), longint'(romIm[mPos]), eTr, eTi);
            mPos++;
            if (mPos == D) begin
                mDrain = 0; mPos = 0; mPrimed = 0;
            end
        end else if (v) begin
            if (mPos < D) begin
                ev = mPrimed;
                eBr = fRe[mPos]; eBi = fIm[mPos];
                cmul(fRe[mPos], fIm[mPos], longint'(romRe[mPos]), longint'(romIm[mPos]), eTr, eTi);
                hRe[mPos] = xr; hIm[mPos] = xi;
            end else begin
                k = mPos - D;
                ev = 1;
                eBr = hRe[k] + xr; eBi = hIm[k] + xi;
                eTr = eBr; eTi = eBi;
                fRe[k] = hRe[k] - xr; fIm[k] = hIm[k] - xi;
            end
            if (lst && (mPos == 2*D-1)) mDrain = 1;
            mPos = (mPos + 1) % (2*D);
            if (mPos == D) mPrimed = 1;
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, then check
    // the registered outputs just after the rising edge.
    task automatic doCycle(input bit v, input int re, input int im, input bit lst);
        bit     ev;
        longint eBr, eBi, eTr, eTi;
        @(negedge iClk);
        dValid = v; dRe = re[DW-1:0]; dIm = im[DW-1:0]; dLast = lst;
        #1;
        checkVal("twIdx", idxTw, (mPos < D) ? mPos : 0);
        checkVal("twIdxByp", idxByp, 0);
        checkVal("busyTw", busyTw, mDrain);
        checkVal("busyByp", busyByp, mDrain);
        if (busyTw) busySeen++;
        modelStep(v, longint'(re), longint'(im), lst, ev, eBr, eBi, eTr, eTi);
        @(posedge iClk);
        #1;
        checkVal("validByp", vByp, ev);
        checkVal("validTw", vTw, ev);
        if (ev) begin
            checkVal("bypRe", $signed(bRe), eBr);
            checkVal("bypIm", $signed(bIm), eBi);
            checkVal("twRe", $signed(tRe), eTr);
            checkVal("twIm", $signed(tIm), eTi);
        end
        if (vByp) capB.push_back(longint'($signed(bRe)));
        if (vTw) begin
            capTRe.push_back(longint'($signed(tRe)));
            capTIm.push_back(longint'($signed(tIm)));
        end
    endtask

    task automatic setRom(input int re, input int im);
        for (int k = 0; k < D; k++) begin
            romRe[k] = re[TWW-1:0];
            romIm[k] = im[TWW-1:0];
        end
    endtask

    task automatic clearCap();
        capB.delete(); capTRe.delete(); capTIm.delete();
        busySeen = 0;
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, "_valid"}, vByp | vTw, 0);
        checkVal({tag, "_bRe"}, bRe, 0);
        checkVal({tag, "_bIm"}, bIm, 0);
        checkVal({tag, "_tRe"}, tRe, 0);
        checkVal({tag, "_tIm"}, tIm, 0);
        checkVal({tag, "_busy"}, busyByp | busyTw, 0);
        checkVal({tag, "_idx"}, idxTw, 0);
    endtask

    // Ramp frame 1..8 with iLast on the final sample, then idle through drain.
    task automatic rampFrame();
        for (int i = 1; i <= 2*D; i++) doCycle(1'b1, i, 0, i == 2*D);
        repeat (D + 2) doCycle(1'b0, 0, 0, 1'b0);
    endtask

    task automatic checkRamp(input string tag);
        longint s1[8] = '{6, 8, 10, 12, -4, -4, -4, -4};
        checkVal({tag, "_count"}, capB.size(), 8);
        checkVal({tag, "_busyCycles"}, busySeen, D);
        if (capB.size() == 8)
            for (int i = 0; i < 8; i++) checkVal({tag, "_out"}, capB[i], s1[i]);
        if (capTRe.size() == 8)
            for (int i = 0; i < D; i++) begin
                checkVal({tag, "_negjRe"}, capTRe[D+i], 0);
                checkVal({tag, "_negjIm"}, capTIm[D+i], 4);
            end
    endtask

    initial begin
        int v, last;
        setRom(0, 0);
        modelReset();
        repeat (2) @(negedge iClk);
        checkResetState("reset");
        Rst = 1'b0;

        // Single frame: bypass sums/differences and -j twiddle drain.
        setRom(0, -128);
        clearCap();
        rampFrame();
        checkRamp("s1");

        // Saturation: both components of every difference are -255.
        setRom(-128, -128);
        clearCap();
        for (int i = 0; i < 2*D; i++)
            doCycle(1'b1, (i < D) ? -128 : 127, (i < D) ? -128 : 127, i == 2*D-1);
        repeat (D + 2) doCycle(1'b0, 0, 0, 1'b0);
        checkVal("s3_count", capTRe.size(), 8);
        if (capTRe.size() == 8)
            for (int i = 0; i < D; i++) begin
                checkVal("s3_satRe", capTRe[D+i], 0);
                checkVal("s3_satIm", capTIm[D+i], 255);
            end

        // Gapped streaming of two frames without iLast, random ROM.
        for (int k = 0; k < D; k++) begin
            romRe[k] = TWW'($urandom_range(255));
            romIm[k] = TWW'($urandom_range(255));
        end
        for (int i = 0; i < 4*D; i++) begin
            doCycle(1'b1, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128, 1'b0);
            doCycle(1'b0, int'($urandom_range(255)) - 128, 0, 1'b1);
        end

        // Misplaced iLast on x3 is ignored; inputs during drain are dropped.
        clearCap();
        for (int i = 0; i < 2*D; i++)
            doCycle(1'b1, 10*(i+1), 0, (i == 2) || (i == 2*D-1));
        for (int i = 0; i < D; i++)
            doCycle(1'b1, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128, 1'b1);
        repeat (2) doCycle(1'b0, 0, 0, 1'b0);
        checkVal("s5_count", capB.size(), 3*D);
        checkVal("s5_busyCycles", busySeen, D);
        if (capB.size() == 3*D)
            for (int i = 0; i < D; i++) checkVal("s5_drain", capB[2*D+i], -40);

        // Reset in the middle of a drain, then a clean frame.
        setRom(0, -128);
        for (int i = 1; i <= 2*D; i++) doCycle(1'b1, i, 0, i == 2*D);
        repeat (2) doCycle(1'b0, 0, 0, 1'b0);
        @(negedge iClk);
        Rst = 1'b1;
        #1;
        checkResetState("s6_rst");
        modelReset();
        @(negedge iClk);
        Rst = 1'b0;
        clearCap();
        rampFrame();
        checkRamp("s6");

        // Random traffic with random ROM, gaps and iLast placement.
        for (int k = 0; k < D; k++) begin
            romRe[k] = TWW'($urandom_range(255));
            romIm[k] = TWW'($urandom_range(255));
        end
        for (int n = 0; n < 1500; n++) begin
            v    = ($urandom_range(3) != 0);
            last = ($urandom_range(5) == 0);
            doCycle(v[0], int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128, last[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
`default_nettype wire
